rrat_retire_map: RTL

//  Retirement RAT plus retired-state free list, generalised to N commit lanes.

---
 rtl/rrat_retire_map_pkg.sv | 37 +++
 rtl/rrat_retire_map_free_fifo.sv | 60 ++++++
 rtl/rrat_retire_map.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rrat_retire_map_pkg.sv
// Shared types, default sizing and pointer helpers for the retirement RAT slice.
package rrat_retire_map_pkg;

   localparam int unsigned DEF_N           = 2;
   localparam int unsigned DEF_ARCH_REG_SZ = 32;
   localparam int unsigned DEF_PHYS_REG_SZ = 64;

   localparam int unsigned ARN_W = $clog2(DEF_ARCH_REG_SZ);
   localparam int unsigned PRN_W = $clog2(DEF_PHYS_REG_SZ);
   localparam int unsigned FL_SZ = DEF_PHYS_REG_SZ - DEF_ARCH_REG_SZ;
   localparam int unsigned FL_W  = $clog2(FL_SZ);

   typedef logic [ARN_W-1:0] arn_t;
   typedef logic [PRN_W-1:0] prn_t;

   typedef struct packed {
      logic valid;
      arn_t arn;
      prn_t prn;
      logic mispred;
   } rrat_commit_packet_t;

   typedef struct packed {
      logic [DEF_ARCH_REG_SZ-1:0][PRN_W-1:0] entries;
      logic [FL_W-1:0]                       head;
      logic [FL_W-1:0]                       tail;
   } rrat_snapshot_t;

   // Circular pointer advance with an explicit modulo so non-power-of-two
   // depths wrap correctly instead of relying on bit truncation.
   function automatic int unsigned wrap_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned size);
      return (ptr + inc) % size;
   endfunction

endpackage

// File: rtl/rrat_retire_map_free_fifo.sv
// Retired-state free list: circular queue with up to N pops and N pushes per
// cycle. Pops and pushes are given as counts; slot k of pop_data/push_data is
// the k-th entry from head/tail respectively.
module rrat_free_fifo
   import rrat_retire_map_pkg::*;
#(
   parameter int unsigned N      = DEF_N,
   parameter int unsigned FL_SZ  = DEF_PHYS_REG_SZ - DEF_ARCH_REG_SZ,
   parameter int unsigned PRN_W  = $clog2(DEF_PHYS_REG_SZ),
   parameter int unsigned BASE   = DEF_ARCH_REG_SZ,
   localparam int unsigned FL_W  = $clog2(FL_SZ),
   localparam int unsigned CNT_W = $clog2(N + 1)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [CNT_W-1:0]            pop_cnt,
   input  logic [CNT_W-1:0]            push_cnt,
   input  logic [N-1:0][PRN_W-1:0]     push_data,
   output logic [N-1:0][PRN_W-1:0]     pop_data,
   output logic [FL_SZ-1:0][PRN_W-1:0] entries,
   output logic [FL_W-1:0]             head,
   output logic [FL_W-1:0]             tail
);

   logic [FL_SZ-1:0][PRN_W-1:0] entries_q;
   logic [FL_W-1:0]             head_q;
   logic [FL_W-1:0]             tail_q;

   // Peek the next N entries starting at head.
   always_comb begin
      pop_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pop_data[k] = entries_q[FL_W'(wrap_add(32'(head_q), k, FL_SZ))];
      end
   end

   // Queue storage and pointer update; reset fills with the initially free prns.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < FL_SZ; k++) begin
            entries_q[k] <= PRN_W'(BASE + k);
         end
         head_q <= '0;
         tail_q <= '0;
      end else begin
         for (int unsigned k = 0; k < N; k++) begin
            if (CNT_W'(k) < push_cnt) begin
               entries_q[FL_W'(wrap_add(32'(tail_q), k, FL_SZ))] <= push_data[k];
            end
         end
         head_q <= FL_W'(wrap_add(32'(head_q), 32'(pop_cnt), FL_SZ));
         tail_q <= FL_W'(wrap_add(32'(tail_q), 32'(push_cnt), FL_SZ));
      end
   end

   assign entries = entries_q;
   assign head    = head_q;
   assign tail    = tail_q;

endmodule

// File: rtl/rrat_retire_map.sv
// Retirement RAT with retired-state free list for N commit lanes. Records
// arn->prn per retiring lane, recycles the previous mapping through the free
// list, and pulses squash with the updated snapshot after a mispredict retires.
module rrat_retire_map
   import rrat_retire_map_pkg::*;
#(
   parameter int unsigned N           = DEF_N,
   parameter int unsigned ARCH_REG_SZ = DEF_ARCH_REG_SZ,
   parameter int unsigned PHYS_REG_SZ = DEF_PHYS_REG_SZ,
   localparam int unsigned ARN_W      = $clog2(ARCH_REG_SZ),
   localparam int unsigned PRN_W      = $clog2(PHYS_REG_SZ),
   localparam int unsigned FL_SZ      = PHYS_REG_SZ - ARCH_REG_SZ,
   localparam int unsigned FL_W       = $clog2(FL_SZ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N-1:0]             commit_valid,
   input  logic [N*ARN_W-1:0]       commit_arn,
   input  logic [N*PRN_W-1:0]       commit_prn,
   input  logic [N-1:0]             commit_mispred,
   output logic [ARCH_REG_SZ*PRN_W-1:0] rrat_entries,
   output logic [N-1:0]             release_valid,
   output logic [N*PRN_W-1:0]       release_prn,
   output logic [FL_W-1:0]          fl_head,
   output logic [FL_W-1:0]          fl_tail,
   output logic [FL_SZ*PRN_W-1:0]   fl_entries,
   output logic                     squash,
   output logic                     desync
);

   localparam int unsigned CNT_W = $clog2(N + 1);
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   logic [ARCH_REG_SZ-1:0][PRN_W-1:0] map_q;
   logic [ARCH_REG_SZ-1:0][PRN_W-1:0] map_n;
   logic [N-1:0]                      rel_valid_q;
   logic [N-1:0]                      rel_valid_n;
   logic [N-1:0][PRN_W-1:0]           rel_prn_q;
   logic [N-1:0][PRN_W-1:0]           rel_prn_n;
   logic                              squash_q;
   logic                              squash_n;
   logic                              desync_q;
   logic                              desync_hit;

   logic [CNT_W-1:0]                  op_cnt;
   logic [N-1:0][PRN_W-1:0]           push_data;
   logic [N-1:0][PRN_W-1:0]           pop_data;
   logic [FL_SZ-1:0][PRN_W-1:0]       fifo_entries;

   // Walk lanes in order: stop at the first gap or after a mispredicting lane.
   // The working map copy forwards same-cycle writes to later lanes, and each
   // non-zero lane takes the next free-list slot in order.
   always_comb begin
      logic              run;
      logic [ARN_W-1:0]  lane_arn;
      logic [PRN_W-1:0]  lane_prn;
      int unsigned       slot;
      map_n       = map_q;
      rel_valid_n = '0;
      rel_prn_n   = '0;
      push_data   = '0;
      squash_n    = 1'b0;
      desync_hit  = 1'b0;
      run         = 1'b1;
      lane_arn    = '0;
      lane_prn    = '0;
      slot        = 0;
      for (int unsigned i = 0; i < N; i++) begin
         lane_arn = commit_arn[i*ARN_W +: ARN_W];
         lane_prn = commit_prn[i*PRN_W +: PRN_W];
         if (run && commit_valid[i]) begin
            if (lane_arn != '0) begin
               rel_valid_n[i]                 = 1'b1;
               rel_prn_n[i]                   = map_n[lane_arn];
               push_data[IDX_W'(slot)]        = map_n[lane_arn];
               if (pop_data[IDX_W'(slot)] != lane_prn) begin
                  desync_hit = 1'b1;
               end
               map_n[lane_arn] = lane_prn;
               slot            = slot + 1;
            end
            if (commit_mispred[i]) begin
               squash_n = 1'b1;
               run      = 1'b0;
            end
         end else begin
            run = 1'b0;
         end
      end
      op_cnt = CNT_W'(slot);
   end

   // Retired map, release report, squash pulse and sticky desync flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ARCH_REG_SZ; i++) begin
            map_q[i] <= PRN_W'(i);
         end
         rel_valid_q <= '0;
         rel_prn_q   <= '0;
         squash_q    <= 1'b0;
         desync_q    <= 1'b0;
      end else begin
         map_q       <= map_n;
         rel_valid_q <= rel_valid_n;
         rel_prn_q   <= rel_prn_n;
         squash_q    <= squash_n;
         desync_q    <= desync_q | desync_hit;
      end
   end

   rrat_free_fifo #(
      .N     (N),
      .FL_SZ (FL_SZ),
      .PRN_W (PRN_W),
      .BASE  (ARCH_REG_SZ)
   ) u_free_fifo (
      .clock     (clock),
      .reset     (reset),
      .pop_cnt   (op_cnt),
      .push_cnt  (op_cnt),
      .push_data (push_data),
      .pop_data  (pop_data),
      .entries   (fifo_entries),
      .head      (fl_head),
      .tail      (fl_tail)
   );

   assign rrat_entries  = map_q;
   assign release_valid = rel_valid_q;
   assign release_prn   = rel_prn_q;
   assign fl_entries    = fifo_entries;
   assign squash        = squash_q;
   assign desync        = desync_q;

endmodule
